pci_init_dma_engine: RTL and testbench

- Synthesizable, parametrised PCI initiator back-end engine on the PCI core's user-side master interface (adio/m_* signals).
- Generalises the fixed-width single-burst behavioural master to a command-driven DMA engine with configurable width and FIFO depth, and separate write and read data FIFOs.
- Adds automatic re-issue after target retry or disconnect, with write-data rewind and a bounded retry count.
- Sits between a local command/data client and the PCI core.

---
 rtl/pci_init_dma_engine_if.sv | 31 +++
 rtl/pci_init_dma_engine.sv | 191 +++++++++++++++++++
 tb/tb_pci_init_dma_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pci_init_dma_engine_if.sv
// User-side master bus between the DMA engine and the PCI core (adio/m_* signals).
// The engine uses the master modport; the core, or a model of it, uses the slave modport.
interface pci_init_dma_engine_if #(
    parameter int DW = 32
);
    localparam int BE_W = DW / 8;

    logic [DW-1:0]   adio_out;
    logic [DW-1:0]   adio_in;
    logic            m_data;
    logic            m_data_vld;
    logic            m_addr_n;
    logic            m_src_en;
    logic [39:0]     csr;
    logic            request;
    logic            requesthold;
    logic            complete;
    logic            m_ready;
    logic [BE_W-1:0] m_cbe;
    logic            m_wrdn;

    modport master (
        input  adio_out, m_data, m_data_vld, m_addr_n, m_src_en, csr,
        output adio_in, request, requesthold, complete, m_ready, m_cbe, m_wrdn
    );

    modport slave (
        output adio_out, m_data, m_data_vld, m_addr_n, m_src_en, csr,
        input  adio_in, request, requesthold, complete, m_ready, m_cbe, m_wrdn
    );
endinterface

// File: rtl/pci_init_dma_engine.sv
// Command-driven PCI initiator DMA engine with write/read FIFOs and retry re-issue.
// Define PCI_INIT_MRM_EN to issue Memory Read Multiple for multi-word reads.
module pci_init_dma_engine #(
    parameter int DW          = 32,
    parameter int ADDR_LENGTH = 5,
    parameter int LEN_W       = 8,
    parameter int RETRY_MAX   = 16
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic [31:0]          cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 wr_push,
    input  logic [DW-1:0]        wr_data,
    output logic                 wr_full,
    input  logic                 rd_pop,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_empty,
    output logic                 done,
    output logic [1:0]           status,
    pci_init_dma_engine_if.master core
);
    localparam int BE_W  = DW / 8;
    localparam int DEPTH = 1 << ADDR_LENGTH;
    localparam int PW    = ADDR_LENGTH + 1;
    localparam int CW    = (LEN_W > PW) ? LEN_W + 1 : PW + 1;
    localparam int RW    = $clog2(RETRY_MAX + 1);
    localparam logic [29:0] WSTEP = 30'(DW / 32);

    typedef enum logic [2:0] {IDLE, REQ, XFER, RECOV, ERR_DONE} state_t;

    state_t           state;
    logic [29:0]      addr_q;
    logic [LEN_W-1:0] rem;
    logic             dir_q;
    logic [RW-1:0]    retry_cnt;
    logic             err_ma, err_ta, cmpl_hold, m_data_q;
    logic             request_q, m_ready_q;

    logic [DW-1:0]    wmem [DEPTH];
    logic [DW-1:0]    rmem [DEPTH];
    // Write FIFO keeps a speculative read pointer and a committed one for rewind.
    logic [PW-1:0]    wr_wptr, wr_rptr, wr_cptr;
    logic [PW-1:0]    rd_wptr, rd_rptr;
    logic [PW-1:0]    wr_cnt, rd_cnt;
    logic [CW-1:0]    rd_free;
    logic             fits, cmd_accept, wr_push_ok, rd_push, complete_c;
    logic [3:0]       rd_cmd;
    logic             unused_in;

    assign wr_cnt     = wr_wptr - wr_cptr;
    assign rd_cnt     = rd_wptr - rd_rptr;
    assign rd_free    = CW'(DEPTH) - CW'(rd_cnt);
    assign wr_full    = (wr_cnt == PW'(DEPTH));
    assign rd_empty   = (rd_wptr == rd_rptr);
    assign rd_data    = rmem[rd_rptr[ADDR_LENGTH-1:0]];
    assign wr_push_ok = wr_push && !wr_full;
    assign rd_push    = (state == XFER) && core.m_data_vld && !dir_q;

    assign fits       = cmd_dir ? (CW'(wr_cnt) >= CW'(cmd_len)) : (rd_free >= CW'(cmd_len));
    assign cmd_ready  = (state == IDLE) && m_ready_q && (cmd_len != '0) && fits;
    assign cmd_accept = cmd_valid && cmd_ready;

`ifdef PCI_INIT_MRM_EN
    assign rd_cmd = (rem >= LEN_W'(2)) ? 4'b1100 : 4'b0110;
`else
    assign rd_cmd = 4'b0110;
`endif

    assign complete_c = (state == XFER) &&
                        (cmpl_hold || (rem == LEN_W'(1)) || ((rem == LEN_W'(2)) && core.m_data_vld));

    assign core.request     = request_q;
    assign core.requesthold = 1'b0;
    assign core.complete    = complete_c;
    assign core.m_ready     = m_ready_q;
    assign core.m_wrdn      = dir_q;
    assign unused_in        = ^{cmd_addr[1:0], core.csr[37:0]};

    always_comb begin
        core.adio_in = '0;
        core.m_cbe   = '0;
        if (state == XFER && !core.m_addr_n) begin
            core.adio_in = DW'({addr_q, 2'b00});
            core.m_cbe   = BE_W'(dir_q ? 4'b0111 : rd_cmd);
        end else if (state == XFER && core.m_data && dir_q) begin
            core.adio_in = wmem[wr_rptr[ADDR_LENGTH-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_push_ok) wmem[wr_wptr[ADDR_LENGTH-1:0]] <= wr_data;
        if (rd_push)    rmem[rd_wptr[ADDR_LENGTH-1:0]] <= core.adio_out;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            rem       <= '0;
            dir_q     <= 1'b0;
            retry_cnt <= '0;
            err_ma    <= 1'b0;
            err_ta    <= 1'b0;
            cmpl_hold <= 1'b0;
            m_data_q  <= 1'b0;
            request_q <= 1'b0;
            m_ready_q <= 1'b0;
            done      <= 1'b0;
            status    <= 2'b00;
            wr_wptr   <= '0;
            wr_rptr   <= '0;
            wr_cptr   <= '0;
            rd_wptr   <= '0;
            rd_rptr   <= '0;
        end else begin
            m_ready_q <= 1'b1;
            request_q <= 1'b0;
            done      <= 1'b0;
            m_data_q  <= core.m_data;
            if (wr_push_ok)         wr_wptr <= wr_wptr + PW'(1);
            if (rd_push)            rd_wptr <= rd_wptr + PW'(1);
            if (rd_pop && !rd_empty) rd_rptr <= rd_rptr + PW'(1);
            case (state)
                IDLE: if (cmd_accept) begin
                    addr_q    <= cmd_addr[31:2];
                    rem       <= cmd_len;
                    dir_q     <= cmd_dir;
                    retry_cnt <= '0;
                    err_ma    <= 1'b0;
                    err_ta    <= 1'b0;
                    request_q <= 1'b1;
                    state     <= REQ;
                end
                REQ: state <= XFER;
                XFER: begin
                    if (dir_q && core.m_src_en) wr_rptr <= wr_rptr + PW'(1);
                    if (core.m_data_vld) begin
                        rem    <= rem - LEN_W'(1);
                        addr_q <= addr_q + WSTEP;
                        if (dir_q) wr_cptr <= wr_cptr + PW'(1);
                    end
                    cmpl_hold <= complete_c && core.m_data;
                    if (core.m_data) begin
                        err_ma <= err_ma | core.csr[39];
                        err_ta <= err_ta | core.csr[38];
                    end
                    // End of the core's data phase decides completion, error or re-issue.
                    if (m_data_q && !core.m_data) begin
                        if (err_ma || err_ta) begin
                            status <= err_ma ? 2'b01 : 2'b10;
                            state  <= ERR_DONE;
                        end else if (rem == '0) begin
                            done   <= 1'b1;
                            status <= 2'b00;
                            state  <= IDLE;
                        end else begin
                            state  <= RECOV;
                        end
                    end
                end
                RECOV: begin
                    wr_rptr   <= wr_cptr;
                    retry_cnt <= retry_cnt + RW'(1);
                    if (retry_cnt == RW'(RETRY_MAX)) begin
                        status <= 2'b11;
                        state  <= ERR_DONE;
                    end else begin
                        err_ma    <= 1'b0;
                        err_ta    <= 1'b0;
                        request_q <= 1'b1;
                        state     <= REQ;
                    end
                end
                ERR_DONE: begin
                    done <= 1'b1;
                    // Drop the unsent words so the FIFO is clean for the next command.
                    if (dir_q) begin
                        wr_rptr <= wr_cptr + PW'(rem);
                        wr_cptr <= wr_cptr + PW'(rem);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pci_init_dma_engine.sv
// Directed bench for pci_init_dma_engine with a simple PCI core model on the slave side.
module tb_pci_init_dma_engine;
    localparam int DW = 32;
    localparam logic [39:0] CSR_RETRY = 40'h10_0000_0000;
    localparam logic [39:0] CSR_MABT  = 40'h80_0000_0000;
`ifdef PCI_INIT_MRM_EN
    localparam logic [3:0] CBE_RDM = 4'b1100;
`else
    localparam logic [3:0] CBE_RDM = 4'b0110;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          reset, cmd_valid, cmd_ready, cmd_dir;
    logic [31:0]   cmd_addr;
    logic [7:0]    cmd_len;
    logic          wr_push, wr_full, rd_pop, rd_empty, done;
    logic [DW-1:0] wr_data, rd_data;
    logic [1:0]    status;

    pci_init_dma_engine_if #(.DW(DW)) bus ();

    pci_init_dma_engine #(.DW(DW), .ADDR_LENGTH(5), .LEN_W(8), .RETRY_MAX(2)) dut (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_push(wr_push), .wr_data(wr_data), .wr_full(wr_full),
        .rd_pop(rd_pop), .rd_data(rd_data), .rd_empty(rd_empty),
        .done(done), .status(status), .core(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    logic [1:0] done_status = 2'b00;
    logic [31:0] wq[$];

    always @(posedge CLK) begin
        if (bus.request) req_cnt++;
        if (done) begin
            done_cnt++;
            done_status = status;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        wr_push = 1'b1;
        wr_data = w;
        if (wq.size() < 32) wq.push_back(w);
        tick();
        wr_push = 1'b0;
    endtask

    task automatic issue(input logic dir, input logic [31:0] addr, input logic [7:0] len);
        cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = addr; cmd_len = len;
        #1;
        chk("cmd_ready_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic reject(input string tag, input logic dir, input logic [7:0] len);
        cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = 32'h0; cmd_len = len;
        #1;
        chk(tag, cmd_ready, 0);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!bus.request && k < 40) begin
            tick();
            k++;
        end
        chk("request_seen", bus.request, 1);
    endtask

    // One core-side transaction: address phase, nvld data words, then m_data drops.
    task automatic core_burst(input logic dir, input int nvld, input logic [39:0] csrv,
                              input logic extra_src, input logic [31:0] exp_addr,
                              input logic [3:0] exp_cbe, input logic exp_last);
        logic [31:0] exp_w;
        wait_req();
        tick();
        bus.m_addr_n = 1'b0;
        #1;
        chk("addr_phase_adio", bus.adio_in, exp_addr);
        chk("addr_phase_cbe", bus.m_cbe, exp_cbe);
        tick();
        bus.m_addr_n = 1'b1;
        if (nvld == 0) begin
            bus.m_data = 1'b1;
            bus.csr    = csrv;
            tick();
        end
        for (int i = 0; i < nvld; i++) begin
            bus.m_data = 1'b1; bus.m_data_vld = 1'b1; bus.m_src_en = dir;
            bus.csr = csrv; bus.adio_out = 32'h11 * (i + 1);
            #1;
            if (dir) begin
                exp_w = (wq.size() > 0) ? wq[0] : 32'hBAD0_BAD0;
                chk("write_data", bus.adio_in, exp_w);
            end
            if (i == nvld - 1) chk("complete_last", bus.complete, exp_last);
            tick();
            if (dir && wq.size() > 0) void'(wq.pop_front());
        end
        bus.m_data = 1'b0; bus.m_data_vld = 1'b0; bus.csr = '0;
        bus.m_src_en = dir & extra_src;
        tick();
        bus.m_src_en = 1'b0;
    endtask

    task automatic wait_done(input int d0, input logic [1:0] exp_st);
        int k = 0;
        while (done_cnt == d0 && k < 40) begin
            tick();
            k++;
        end
        chk("done_pulse", done_cnt, d0 + 1);
        chk("done_status", done_status, exp_st);
    endtask

    initial begin
        int d0, r0;
        reset = 1'b1; cmd_valid = 0; cmd_dir = 0; cmd_addr = 0; cmd_len = 0;
        wr_push = 0; wr_data = 0; rd_pop = 0;
        bus.adio_out = 0; bus.m_data = 0; bus.m_data_vld = 0; bus.m_addr_n = 1;
        bus.m_src_en = 0; bus.csr = 0;
        repeat (3) tick();
        chk("rst_request", bus.request, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_m_ready", bus.m_ready, 0);
        chk("rst_status", status, 0);
        chk("rst_rd_empty", rd_empty, 1);
        chk("rst_wr_full", wr_full, 0);
        reset = 1'b0;
        tick();
        chk("m_ready_after_rst", bus.m_ready, 1);
        reject("reject_len0", 1'b0, 8'd0);
        reject("reject_wr_no_data", 1'b1, 8'd1);

        // Single write
        push_word(32'hDEADBEEF);
        d0 = done_cnt; r0 = req_cnt;
        issue(1'b1, 32'h0000_1000, 8'd1);
        core_burst(1'b1, 1, '0, 1'b0, 32'h0000_1000, 4'b0111, 1'b1);
        wait_done(d0, 2'b00);
        chk("single_req_pulses", req_cnt - r0, 1);

        // Read burst
        d0 = done_cnt;
        issue(1'b0, 32'h0000_2000, 8'd4);
        core_burst(1'b0, 4, '0, 1'b0, 32'h0000_2000, CBE_RDM, 1'b1);
        wait_done(d0, 2'b00);
        for (int j = 0; j < 4; j++) begin
            chk("rd_not_empty", rd_empty, 0);
            chk("rd_data", rd_data, 32'h11 * (j + 1));
            rd_pop = 1'b1;
            tick();
            rd_pop = 1'b0;
        end
        chk("rd_empty_after", rd_empty, 1);
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        chk("rd_pop_empty_ignored", rd_empty, 1);

        // Disconnect after 3 words, with one prefetched word to rewind
        for (int i = 0; i < 8; i++) push_word(32'hA0A0_0000 + i);
        d0 = done_cnt; r0 = req_cnt;
        issue(1'b1, 32'h0000_1000, 8'd8);
        core_burst(1'b1, 3, CSR_RETRY, 1'b1, 32'h0000_1000, 4'b0111, 1'b0);
        core_burst(1'b1, 5, '0, 1'b0, 32'h0000_100C, 4'b0111, 1'b1);
        wait_done(d0, 2'b00);
        chk("disc_req_pulses", req_cnt - r0, 2);

        // Retry limit
        push_word(32'h0000_0077);
        d0 = done_cnt; r0 = req_cnt;
        issue(1'b1, 32'h0000_3000, 8'd1);
        for (int a = 0; a < 3; a++)
            core_burst(1'b1, 0, CSR_RETRY, 1'b0, 32'h0000_3000, 4'b0111, 1'b0);
        wait_done(d0, 2'b11);
        chk("retry_req_pulses", req_cnt - r0, 3);
        wq.delete();
        reject("reject_after_discard", 1'b1, 8'd1);

        // Master abort, then a normal command
        d0 = done_cnt;
        issue(1'b0, 32'h0000_4000, 8'd2);
        core_burst(1'b0, 0, CSR_MABT, 1'b0, 32'h0000_4000, CBE_RDM, 1'b0);
        wait_done(d0, 2'b01);
        chk("mabt_rd_empty", rd_empty, 1);
        push_word(32'h5555AAAA);
        d0 = done_cnt;
        issue(1'b1, 32'h0000_5000, 8'd1);
        core_burst(1'b1, 1, '0, 1'b0, 32'h0000_5000, 4'b0111, 1'b1);
        wait_done(d0, 2'b00);

        // FIFO full boundary: the 33rd push is dropped
        for (int i = 0; i < 33; i++) push_word(32'hC000_0000 + i);
        chk("wr_full", wr_full, 1);
        reject("reject_wr_len33", 1'b1, 8'd33);
        reject("reject_rd_len33", 1'b0, 8'd33);
        d0 = done_cnt;
        issue(1'b1, 32'h0000_6000, 8'd32);
        core_burst(1'b1, 32, '0, 1'b0, 32'h0000_6000, 4'b0111, 1'b1);
        wait_done(d0, 2'b00);
        chk("wr_not_full_after", wr_full, 0);

        // Reset in the middle of a burst with rem = 5 and the write FIFO full
        for (int i = 0; i < 29; i++) push_word(32'hD000_0000 + i);
        d0 = done_cnt;
        issue(1'b1, 32'h0000_7000, 8'd8);
        wait_req();
        tick();
        bus.m_addr_n = 1'b0;
        tick();
        bus.m_addr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.m_data = 1'b1; bus.m_data_vld = 1'b1; bus.m_src_en = 1'b1;
            tick();
        end
        bus.m_data_vld = 1'b0; bus.m_src_en = 1'b0;
        for (int i = 0; i < 6; i++) push_word(32'hE000_0000 + i);
        chk("mid_wr_full", wr_full, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_request", bus.request, 0);
        chk("mid_rst_wr_full", wr_full, 0);
        chk("mid_rst_rd_empty", rd_empty, 1);
        chk("mid_rst_done", done, 0);
        reset = 1'b0; bus.m_data = 1'b0;
        wq.delete();
        repeat (3) tick();
        chk("mid_rst_no_done", done_cnt, d0);
        chk("mid_rst_m_ready", bus.m_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
